// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer.
//   DATA_W : ALU operand width (results are 2*DATA_W wide)
//   OP_W   : ALU opcode width
//   cmd_t  : one buffered command {op, a, b}
//   res_t  : one captured result {op, y, carry, zero}
//   tag_t  : one in-flight marker {valid, op}
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [2*DATA_W-1:0] y;
    logic                carry;
    logic                zero;
  } res_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
  } tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a combinational read port.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data (ignored when full)
//   pop        : read request (ignored when empty); rdata shows the head
//   full/empty : status flags derived from the pointers
//   count      : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    // The extra MSB distinguishes "same slot, same lap" (empty) from
    // "same slot, one lap apart" (full).
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream feeder for the 8-bit ALU.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command input (valid/ready)
//   alu_a/alu_b/alu_s/alu_en               : drive the ALU; alu_en pulses
//                                            once per issued command
//   alu_y/alu_carry/alu_zero               : ALU outputs, ALU_LAT cycles
//                                            after the ALU samples en
//   res_valid/res_ready/res_y/res_carry/
//   res_zero/res_op                        : result output (valid/ready)
//   busy                                   : work buffered, in flight or
//                                            waiting to be consumed
// Commands are issued only against a credit: one credit per free result
// FIFO slot not already claimed by an in-flight command, so a captured
// result always has somewhere to go even when the consumer stalls.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_s,
  output logic                alu_en,
  input  logic [2*DATA_W-1:0] alu_y,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] res_y,
  output logic                res_carry,
  output logic                res_zero,
  output logic [OP_W-1:0]     res_op,
  output logic                busy
);

  localparam int CRED_W = $clog2(RES_DEPTH + 1);
  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RES_CW = $clog2(RES_DEPTH) + 1;

  cmd_t              cmd_wdata, cmd_head;
  logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_CW-1:0] cmd_count, cmd_count_nxt;

  res_t              res_wdata, res_head;
  logic              res_push, res_pop, res_full, res_empty;
  logic [RES_CW-1:0] res_count;

  logic              cmd_ready_q, cmd_ready_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  cmd_t              hold_q, hold_d;
  tag_t              tag_q [ALU_LAT];
  tag_t              tag_d [ALU_LAT];
  logic              issue;
  logic              tag_busy;
  logic              unused_ok;

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_push),
    .wdata (res_wdata),
    .pop   (res_pop),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_comb begin
    // NOTE: every variable gets a value on every path through this block
    // (defaults first), otherwise synthesis infers a latch.
    tag_busy  = 1'b0;
    cmd_push  = cmd_valid & cmd_ready_q;
    cmd_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b};
    res_pop   = ~res_empty & res_ready;

    // A result leaving this cycle frees a slot, so a zero credit count
    // can still issue: the new result lands at least one edge later.
    issue   = ~cmd_empty & ((credits_q != '0) | res_pop);
    cmd_pop = issue;

    credits_d = credits_q - CRED_W'(issue) + CRED_W'(res_pop);

    // cmd_ready is registered: predict fullness after this edge.
    cmd_count_nxt = cmd_count + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
    cmd_ready_d   = (cmd_count_nxt != CMD_CW'(CMD_DEPTH));

    hold_d = issue ? cmd_head : hold_q;

    // Stage 0 of the tag pipe is the issue cycle itself; tag_q holds the
    // remaining ALU_LAT stages, and the last one lines up with alu_y.
    tag_d[0] = '{valid: issue, op: issue ? cmd_head.op : '0};
    for (int i = 1; i < ALU_LAT; i++) tag_d[i] = tag_q[i-1];
    for (int i = 0; i < ALU_LAT; i++) tag_busy = tag_busy | tag_q[i].valid;

    res_push  = tag_q[ALU_LAT-1].valid;
    res_wdata = '{op: tag_q[ALU_LAT-1].op, y: alu_y,
                  carry: alu_carry, zero: alu_zero};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b0;
      credits_q   <= CRED_W'(RES_DEPTH);
      hold_q      <= '0;
      for (int i = 0; i < ALU_LAT; i++) tag_q[i] <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      credits_q   <= credits_d;
      hold_q      <= hold_d;
      for (int i = 0; i < ALU_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  // Operands follow the FIFO head in the issue cycle and hold otherwise.
  assign alu_en    = issue;
  assign alu_a     = hold_d.a;
  assign alu_b     = hold_d.b;
  assign alu_s     = hold_d.op;
  assign cmd_ready = cmd_ready_q;

  // Head fields are masked so an empty FIFO never exposes stale storage.
  assign res_valid = ~res_empty;
  assign res_y     = res_valid ? res_head.y     : '0;
  assign res_carry = res_valid ? res_head.carry : 1'b0;
  assign res_zero  = res_valid ? res_head.zero  : 1'b0;
  assign res_op    = res_valid ? res_head.op    : '0;

  assign busy = ~cmd_empty | tag_busy | ~res_empty;

  // Status the credit scheme makes redundant.
  assign unused_ok = ^{cmd_full, res_full, res_count};

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: models a 1-cycle-latency ALU,
// predicts every result from the accepted command stream into a queue, and
// compares them in order whenever the DUT hands a result over.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] y;
    logic        c;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_s;
  logic        alu_en;
  logic [15:0] alu_y = '0;
  logic        alu_carry = 1'b0;
  logic        alu_zero = 1'b0;
  logic        res_valid, res_ready;
  logic [15:0] res_y;
  logic        res_carry, res_zero;
  logic [3:0]  res_op;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   en_count = 0;
  int   en_run = 0;
  int   en_max = 0;
  bit   drv_done, rand_done;
  exp_t exp_q[$];
  logic [16:0] alu_r;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_en    (alu_en),
    .alu_y     (alu_y),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_op    (res_op),
    .busy      (busy)
  );

  // ALU behaviour: returns {carry, y}. 0001 add, 0010 subtract (carry =
  // borrow), anything else multiply with carry clear.
  function automatic logic [16:0] alu_fn(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] wa, wb, t;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (op)
      4'b0001: begin t = wa + wb; return {t[8], t}; end
      4'b0010: begin t = wa - wb; return {a < b, 8'h00, t[7:0]}; end
      default: return {1'b0, wa * wb};
    endcase
  endfunction

  // One-cycle-latency ALU.
  always @(posedge clk) begin
    if (alu_en) begin
      alu_r      = alu_fn(alu_s, alu_a, alu_b);
      alu_y     <= alu_r[15:0];
      alu_carry <= alu_r[16];
      alu_zero  <= (alu_r[15:0] == 16'h0000);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: predict on accept, compare on every result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [16:0] r;
      exp_t        e;
      if (alu_en) begin en_count++; en_run++; end
      else en_run = 0;
      if (en_run > en_max) en_max = en_run;
      if (cmd_valid && cmd_ready) begin
        r = alu_fn(cmd_op, cmd_a, cmd_b);
        exp_q.push_back('{op: cmd_op, y: r[15:0], c: r[16],
                          z: (r[15:0] == 16'h0000)});
      end
      if (res_valid && res_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("res_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("res", {10'b0, res_op, res_y, res_carry, res_zero},
                {10'b0, e.op, e.y, e.c, e.z});
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    int  n = 0;
    bit  ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else n++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("send_timeout", ok, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 3000), 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_alu_en", alu_en, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_res_y", res_y, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_cmd_ready_low", cmd_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_cmd_ready_high", cmd_ready, 1'b1);

    // Single op: cycle 1 handshake, cycle 2 alu_en, cycle 4 res_valid.
    cmd_valid = 1'b1; cmd_op = 4'b0001; cmd_a = 8'hEE; cmd_b = 8'hEE;
    @(negedge clk);
    check("c1_alu_en", alu_en, 1'b0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("c2_alu_en", alu_en, 1'b1);
    check("c2_alu_a", alu_a, 8'hEE);
    check("c2_alu_s", alu_s, 4'b0001);
    @(negedge clk);
    check("c3_alu_en", alu_en, 1'b0);
    check("c3_res_valid", res_valid, 1'b0);
    check("c3_alu_a_hold", alu_a, 8'hEE);
    @(negedge clk);
    check("c4_res_valid", res_valid, 1'b1);
    check("c4_res_y", res_y, 16'h01DC);
    wait_drain();

    // Back-to-back burst.
    en_max = 0;
    send(4'b0001, 8'hEE, 8'hEE);
    send(4'b0010, 8'hEE, 8'hEE);
    send(4'b0010, 8'hEE, 8'hEE);
    send(4'b0001, 8'h12, 8'h34);
    send(4'b0010, 8'h05, 8'h09);
    wait_drain();
    check("burst_en_run", en_max, 5);

    // Backpressure: 10 commands with the consumer stalled.
    res_ready = 1'b0;
    en_count = 0; pops = 0; drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(4'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
        drv_done = 1'b1;
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    check("bp_en_pulses", en_count, 4);
    check("bp_cmd_ready", cmd_ready, 1'b0);
    check("bp_accepted", exp_q.size(), 8);
    res_ready = 1'b1;
    for (int n = 0; n < 200 && !drv_done; n++) @(posedge clk);
    #1;
    check("bp_driver_done", drv_done, 1'b1);
    wait_drain();
    check("bp_pops", pops, 10);
    check("bp_en_total", en_count, 10);

    // Pop and issue in the same cycle with zero credits.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(4'b0001, 8'(i * 16), 8'(i + 3));
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("full_stalled", alu_en, 1'b0);
    check("full_res_valid", res_valid, 1'b1);
    @(posedge clk); #1;
    p0 = pops;
    res_ready = 1'b1;
    @(negedge clk);
    check("pop_issue_same_cycle", alu_en, 1'b1);
    @(posedge clk); #1 res_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("refill_one_pop", pops - p0, 1);
    check("refill_res_valid", res_valid, 1'b1);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_drain();
    check("refill_total", pops - p0, 5);

    // Randomized traffic with a randomly stalling consumer.
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if (!rand_done) res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end else begin
        send(4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
    end
    rand_done = 1'b1;
    @(posedge clk); #2 res_ready = 1'b1;
    wait_drain();

    // Reset with work in flight.
    res_ready = 1'b0;
    send(4'b0001, 8'h01, 8'h02);
    send(4'b0010, 8'h07, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_alu_en", alu_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    p0 = pops;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check("mid_rel_cmd_ready_low", cmd_ready, 1'b0);
    @(posedge clk); #1;
    check("mid_rel_cmd_ready", cmd_ready, 1'b1);
    res_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale_res_valid", res_valid, 1'b0);
    check("no_stale_pops", pops - p0, 0);
    check("no_stale_busy", busy, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
